// File: rtl/cas_sort_pkg.sv
// Shared types, default sizes and pair-count helper for the odd-even transposition sorter.
package cas_sort_pkg;
    localparam int DEF_BITS     = 8;
    localparam int DEF_NUM_ELEM = 8;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Even phases cover every pair; odd phases skip the wrap-around pair.
    function automatic int num_pairs(input logic parity, input int n);
        return parity ? (n / 2 - 1) : (n / 2);
    endfunction
endpackage

// File: rtl/cas_sort_ctrl_if.sv
// Input/output streams plus status of the sorting controller.
interface cas_sort_ctrl_if
    import cas_sort_pkg::*;
#(
    parameter int BITS = DEF_BITS
);
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out_data;
    logic            busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/cas_sort_ctrl_cas.sv
// Combinational compare-and-swap: the larger word leaves on a_new, the smaller on b_new.
module cas
    import cas_sort_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic [BITS-1:0] a_new,
    output logic [BITS-1:0] b_new
);
    logic w_swap;

    assign w_swap = (b > a);
    assign a_new  = w_swap ? b : a;
    assign b_new  = w_swap ? a : b;
endmodule

// File: rtl/cas_sort_ctrl.sv
// Load / odd-even transposition sort / drain controller around one shared cas unit.
// Optional: define CAS_SORT_EARLY_EXIT_EN to leave SORT after two consecutive swap-free phases.
module cas_sort_ctrl
    import cas_sort_pkg::*;
#(
    parameter int BITS     = DEF_BITS,
    parameter int NUM_ELEM = DEF_NUM_ELEM
) (
    input  logic           clk,
    input  logic           rst,
    cas_sort_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_ELEM);
    localparam int PH_W  = IDX_W + 1;

    localparam logic [1:0] S_LOAD  = ST_LOAD;
    localparam logic [1:0] S_SORT  = ST_SORT;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;

    logic [1:0]       r_state;
    logic [BITS-1:0]  r_mem [NUM_ELEM];
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic [IDX_W-1:0] r_pair;
    logic [PH_W-1:0]  r_phase;

    logic             w_par;
    logic [IDX_W-1:0] w_j;
    logic [IDX_W-1:0] w_j1;
    logic [BITS-1:0]  w_a_new;
    logic [BITS-1:0]  w_b_new;
    logic             w_last_pair;
    logic             w_last_phase;
    logic             w_sort_done;

    assign w_par        = r_phase[0];
    assign w_j          = IDX_W'({r_pair, 1'b0} | {{IDX_W{1'b0}}, w_par});
    assign w_j1         = w_j + IDX_W'(1);
    assign w_last_pair  = (int'(r_pair) == num_pairs(w_par, NUM_ELEM) - 1);
    assign w_last_phase = (r_phase == PH_W'(NUM_ELEM - 1));

    cas #(
        .BITS (BITS)
    ) u_cas (
        .a     (r_mem[w_j]),
        .b     (r_mem[w_j1]),
        .a_new (w_a_new),
        .b_new (w_b_new)
    );

`ifdef CAS_SORT_EARLY_EXIT_EN
    logic r_swap_cur;
    logic r_swap_prev;
    logic w_swap_now;

    assign w_swap_now  = (w_a_new != r_mem[w_j]);
    assign w_sort_done = w_last_pair &&
                         (w_last_phase ||
                          ((r_phase != '0) && !r_swap_prev && !(r_swap_cur || w_swap_now)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_swap_cur  <= 1'b0;
            r_swap_prev <= 1'b0;
        end else if (r_state == S_SORT) begin
            if (w_last_pair) begin
                r_swap_prev <= r_swap_cur | w_swap_now;
                r_swap_cur  <= 1'b0;
            end else begin
                r_swap_cur  <= r_swap_cur | w_swap_now;
            end
        end else begin
            r_swap_cur  <= 1'b0;
            r_swap_prev <= 1'b0;
        end
    end
`else
    assign w_sort_done = w_last_pair && w_last_phase;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_LOAD;
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_pair   <= '0;
            r_phase  <= '0;
            for (int i = 0; i < NUM_ELEM; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (bus.in_valid) begin
                        r_mem[r_wr_idx] <= bus.in_data;
                        if (r_wr_idx == IDX_W'(NUM_ELEM - 1)) begin
                            r_state  <= S_SORT;
                            r_wr_idx <= '0;
                            r_phase  <= '0;
                            r_pair   <= '0;
                        end else begin
                            r_wr_idx <= r_wr_idx + IDX_W'(1);
                        end
                    end
                end
                S_SORT: begin
                    r_mem[w_j]  <= w_a_new;
                    r_mem[w_j1] <= w_b_new;
                    if (w_sort_done) begin
                        r_state  <= S_DRAIN;
                        r_rd_idx <= '0;
                    end else if (w_last_pair) begin
                        r_pair  <= '0;
                        r_phase <= r_phase + PH_W'(1);
                    end else begin
                        r_pair  <= r_pair + IDX_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (bus.out_ready) begin
                        if (r_rd_idx == IDX_W'(NUM_ELEM - 1)) begin
                            r_state  <= S_LOAD;
                            r_rd_idx <= '0;
                        end else begin
                            r_rd_idx <= r_rd_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    // Handshake outputs depend on state only; out_data is zero whenever nothing is offered.
    assign bus.in_ready  = (r_state == S_LOAD);
    assign bus.out_valid = (r_state == S_DRAIN);
    assign bus.busy      = (r_state == S_SORT) || (r_state == S_DRAIN);
    assign bus.out_data  = (r_state == S_DRAIN) ? r_mem[r_rd_idx] : '0;
endmodule

// File: tb/tb_cas_sort_ctrl.sv
// Directed table plus hand-written corner sequences and throttled random blocks for cas_sort_ctrl.
module tb_cas_sort_ctrl;
    import cas_sort_pkg::*;

    localparam int BITS = 8;
    localparam int N    = 8;
`ifdef CAS_SORT_EARLY_EXIT_EN
    localparam int PRESORT_CYC = 7;
`else
    localparam int PRESORT_CYC = 28;
`endif

    typedef logic [N-1:0][BITS-1:0] blk_t;

    typedef struct {
        blk_t in_w;
        blk_t exp_w;
        int   exp_sort;
        int   stall_at;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    cas_sort_ctrl_if #(.BITS(BITS)) bus ();

    cas_sort_ctrl #(
        .BITS     (BITS),
        .NUM_ELEM (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic blk_t pk(input int a0, input int a1, input int a2, input int a3,
                                input int a4, input int a5, input int a6, input int a7);
        blk_t r;
        r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
        r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7);
        return r;
    endfunction

    function automatic blk_t ref_sort(input blk_t w);
        blk_t r;
        logic [BITS-1:0] t;
        r = w;
        for (int i = 1; i < N; i++) begin
            for (int k = i; k > 0; k--) begin
                if (r[k] > r[k-1]) begin
                    t = r[k]; r[k] = r[k-1]; r[k-1] = t;
                end
            end
        end
        return r;
    endfunction

    task automatic load_block(input blk_t w, input bit thr);
        int  i;
        int  cnt;
        bit  hs;
        i = 0; cnt = 0;
        while (i < N && cnt < 1000) begin
            bus.in_valid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data  = w[i];
            @(negedge clk);
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            cnt++;
            if (hs) i++;
        end
        bus.in_valid = 1'b0;
        check("load_done", i, N);
    endtask

    task automatic sort_wait(input bit noise, output int n);
        int guard;
        n = 0; guard = 0;
        if (noise) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 8'hEE;
            bus.out_ready = 1'b1;
        end
        while (!bus.out_valid && guard < 200) begin
            if (bus.busy) n++;
            @(posedge clk); #1;
            guard++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("sort_ended", bus.out_valid, 1);
    endtask

    task automatic drain_block(input blk_t exp, input bit thr, input int stall_at,
                               output blk_t got, output int cyc);
        int k;
        int stall_left;
        k = 0; cyc = 0; stall_left = 3; got = '0;
        while (k < N && cyc < 1000) begin
            bus.out_ready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
            if (k == stall_at && stall_left > 0) bus.out_ready = 1'b0;
            @(negedge clk);
            if (k == stall_at && stall_left > 0) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, exp[k]);
                stall_left--;
            end
            if (bus.out_valid && bus.out_ready) begin
                got[k] = bus.out_data;
                k++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.out_ready = 1'b0;
        check("drain_done", k, N);
        check("back_to_load", bus.in_ready, 1);
        check("idle_busy", bus.busy, 0);
        check("idle_valid", bus.out_valid, 0);
    endtask

    vec_t vecs [5];
    blk_t got;
    blk_t w;
    blk_t exp_blk;
    int   sc;
    int   cyc;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        #2;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_out_data", bus.out_data, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        vecs[0] = '{pk(1,2,3,4,5,6,7,8),       pk(8,7,6,5,4,3,2,1),       28,          -1};
        vecs[1] = '{pk(8,7,6,5,4,3,2,1),       pk(8,7,6,5,4,3,2,1),       PRESORT_CYC, -1};
        vecs[2] = '{pk(5,5,5,5,0,255,0,255),   pk(255,255,5,5,5,5,0,0),   28,           2};
        vecs[3] = '{pk(7,7,7,7,7,7,7,7),       pk(7,7,7,7,7,7,7,7),       PRESORT_CYC, -1};
        vecs[4] = '{pk(0,0,0,0,0,0,0,255),     pk(255,0,0,0,0,0,0,0),     28,          -1};

        for (int v = 0; v < 5; v++) begin
            load_block(vecs[v].in_w, 1'b0);
            sort_wait(v == 0, sc);
            check("sort_cycles", sc, vecs[v].exp_sort);
            drain_block(vecs[v].exp_w, 1'b0, vecs[v].stall_at, got, cyc);
            for (int k = 0; k < N; k++) check("vec_word", got[k], vecs[v].exp_w[k]);
            check("drain_cycles", cyc, (vecs[v].stall_at >= 0) ? N + 3 : N);
            $display("vector %0d sort_cycles=%0d drain_cycles=%0d", v, sc, cyc);
        end

        // Reset asserted in the tenth SORT cycle, then a fresh block must sort cleanly.
        load_block(pk(200,201,202,203,204,205,206,207), 1'b0);
        repeat (9) @(posedge clk);
        #2;
        check("mid_busy", bus.busy, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_out_data", bus.out_data, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_valid", bus.out_valid, 0);
            check("post_rst_ready", bus.in_ready, 1);
        end
        load_block(pk(9,10,11,12,13,14,15,16), 1'b0);
        sort_wait(1'b0, sc);
        check("fresh_sort_cycles", sc, 28);
        exp_blk = pk(16,15,14,13,12,11,10,9);
        drain_block(exp_blk, 1'b0, -1, got, cyc);
        for (int k = 0; k < N; k++) check("fresh_word", got[k], exp_blk[k]);
        $display("reset block sort_cycles=%0d drain_cycles=%0d", sc, cyc);

        for (int b = 0; b < 500; b++) begin
            for (int i = 0; i < N; i++) w[i] = 8'($urandom);
            exp_blk = ref_sort(w);
            load_block(w, 1'b1);
            sort_wait(1'b0, sc);
            drain_block(exp_blk, 1'b1, -1, got, cyc);
            for (int k = 0; k < N; k++) begin
                check("rand_word", got[k], exp_blk[k]);
                if (k > 0) check("rand_nonincr", 32'(got[k] > got[k-1]), 0);
            end
            $display("random block %0d sort_cycles=%0d drain_cycles=%0d", b, sc, cyc);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
